// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared state encodings and default widths for the data-memory arbiter
package dmem_arbiter_pkg;
    localparam int DMEM_DW = 32;
    localparam int DMEM_AW = 8;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        P_ACC  = 2'd1,
        P_DONE = 2'd2,
        D_ACC  = 2'd3
    } arb_state_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: variable-latency req/ack data-memory port (master = arbiter, slave = memory)
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int DW = DMEM_DW,
    parameter int AW = DMEM_AW
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dmem_arb_age_cnt.sv
// dmem_arb_age_cnt: saturating count of consecutive cycles the DMA requester has waited
module dmem_arb_age_cnt #(
    parameter int MAX_WAIT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inc,
    input  logic                          clr,
    output logic [$clog2(MAX_WAIT+1)-1:0] count,
    output logic                          sat
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    assign sat = count == CW'(MAX_WAIT);

    // clear wins over increment; hold once saturated
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else if (clr) count <= '0;
        else if (inc && !sat) count <= count + 1'b1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the MEM stage and a DMA port; optional ack timeout via DMEM_ARB_TIMEOUT_EN
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DW       = DMEM_DW,
    parameter int AW       = DMEM_AW,
    parameter int MAX_WAIT = 8
`ifdef DMEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 64
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_rd,
    input  logic          pipe_wr,
    input  logic [AW-1:0] pipe_addr,
    input  logic [DW-1:0] pipe_wdata,
    output logic [DW-1:0] pipe_rdata,
    output logic          stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_done,
    output logic [DW-1:0] dma_rdata,
    dmem_arbiter_if.master mem
`ifdef DMEM_ARB_TIMEOUT_EN
    ,
    output logic          err
`endif
);
    arb_state_t state;
    logic pipe_acc;
    logic dma_win;
    logic age_sat;
    logic [$clog2(MAX_WAIT+1)-1:0] age_unused;

    assign pipe_acc = pipe_rd | pipe_wr;
    assign dma_win  = dma_req & (age_sat | ~pipe_acc);
    // gated by rst so the pipeline is released the instant reset asserts
    assign stall    = rst & pipe_acc & (state != P_DONE);

    dmem_arb_age_cnt #(.MAX_WAIT(MAX_WAIT)) u_age (
        .clk   (clk),
        .rst   (rst),
        .inc   (dma_req & (state != D_ACC)),
        .clr   (~dma_req | ((state == IDLE) & dma_win)),
        .count (age_unused),
        .sat   (age_sat)
    );

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic t_exp;

    assign t_exp = tcnt == TW'(TIMEOUT - 1);

    // cycles spent waiting for ack in the current access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tcnt <= '0;
        else tcnt <= (state == P_ACC || state == D_ACC) ? tcnt + 1'b1 : '0;
    end
`endif

    // arbitration FSM with registered memory-port and completion outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem.req    <= 1'b0;
            mem.we     <= 1'b0;
            mem.addr   <= '0;
            mem.wdata  <= '0;
            dma_gnt    <= 1'b0;
            dma_done   <= 1'b0;
            pipe_rdata <= '0;
            dma_rdata  <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
            err        <= 1'b0;
`endif
        end else begin
            dma_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dma_win) begin
                        state     <= D_ACC;
                        mem.req   <= 1'b1;
                        mem.we    <= dma_we;
                        mem.addr  <= dma_addr;
                        mem.wdata <= dma_wdata;
                        dma_gnt   <= 1'b1;
                    end else if (pipe_acc) begin
                        state     <= P_ACC;
                        mem.req   <= 1'b1;
                        mem.we    <= pipe_wr;
                        mem.addr  <= pipe_addr;
                        mem.wdata <= pipe_wdata;
                    end
                end
                P_ACC: begin
                    if (mem.ack) begin
                        mem.req <= 1'b0;
                        if (!mem.we) pipe_rdata <= mem.rdata;
                        state <= P_DONE;
                    end
`ifdef DMEM_ARB_TIMEOUT_EN
                    else if (t_exp) begin
                        mem.req    <= 1'b0;
                        pipe_rdata <= '0;
                        err        <= 1'b1;
                        state      <= P_DONE;
                    end
`endif
                end
                P_DONE: state <= IDLE;
                D_ACC: begin
                    if (mem.ack) begin
                        mem.req  <= 1'b0;
                        dma_gnt  <= 1'b0;
                        dma_done <= 1'b1;
                        if (!mem.we) dma_rdata <= mem.rdata;
                        state <= IDLE;
                    end
`ifdef DMEM_ARB_TIMEOUT_EN
                    else if (t_exp) begin
                        mem.req   <= 1'b0;
                        dma_gnt   <= 1'b0;
                        dma_done  <= 1'b1;
                        dma_rdata <= '0;
                        err       <= 1'b1;
                        state     <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: cycle-table and directed-sequence checks for dmem_arbiter
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_rd = 1'b0;
    logic        pipe_wr = 1'b0;
    logic [7:0]  pipe_addr = '0;
    logic [31:0] pipe_wdata = '0;
    logic [31:0] pipe_rdata;
    logic        stall;
    logic        dma_req = 1'b0;
    logic        dma_we = 1'b0;
    logic [7:0]  dma_addr = '0;
    logic [31:0] dma_wdata = '0;
    logic        dma_gnt;
    logic        dma_done;
    logic [31:0] dma_rdata;
`ifdef DMEM_ARB_TIMEOUT_EN
    logic        err;
`endif

    int total = 0;
    int bad = 0;

    dmem_arbiter_if #(.DW(32), .AW(8)) m ();

    dmem_arbiter #(
        .DW(32), .AW(8), .MAX_WAIT(8)
`ifdef DMEM_ARB_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .stall(stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_done(dma_done),
        .dma_rdata(dma_rdata), .mem(m.master)
`ifdef DMEM_ARB_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctl;
        logic [7:0]  pa;
        logic [31:0] pwd;
        logic [7:0]  da;
        logic [31:0] rd;
        logic [4:0]  o;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] pr;
        logic [31:0] dr;
    } vec_t;

    vec_t tv[20];
    logic [13:0] stall_c = 14'b01111011011011;
    logic [13:0] req_c = 14'b01010010010010;

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        int n;
        bit seen;
        // ctl = {pipe_rd, pipe_wr, dma_req, mem_ack}; o = {stall, mem_req, mem_we, dma_gnt, dma_done}
        tv[0]  = '{4'b1000, 8'h10, 32'h0,  8'h00, 32'h0,        5'b10000, 8'h00, 32'h0,  32'h0,        32'h0};
        tv[1]  = '{4'b1000, 8'h10, 32'h0,  8'h00, 32'h0,        5'b11000, 8'h10, 32'h0,  32'h0,        32'h0};
        tv[2]  = '{4'b1000, 8'h10, 32'h0,  8'h00, 32'h0,        5'b11000, 8'h10, 32'h0,  32'h0,        32'h0};
        tv[3]  = '{4'b1001, 8'h10, 32'h0,  8'h00, 32'hDEADBEEF, 5'b11000, 8'h10, 32'h0,  32'h0,        32'h0};
        tv[4]  = '{4'b1000, 8'h10, 32'h0,  8'h00, 32'h0,        5'b00000, 8'h10, 32'h0,  32'hDEADBEEF, 32'h0};
        tv[5]  = '{4'b0000, 8'h00, 32'h0,  8'h00, 32'h0,        5'b00000, 8'h10, 32'h0,  32'hDEADBEEF, 32'h0};
        tv[6]  = '{4'b0110, 8'h04, 32'h55, 8'h20, 32'h0,        5'b10000, 8'h10, 32'h0,  32'hDEADBEEF, 32'h0};
        tv[7]  = '{4'b0111, 8'h04, 32'h55, 8'h20, 32'h0,        5'b11100, 8'h04, 32'h55, 32'hDEADBEEF, 32'h0};
        tv[8]  = '{4'b0110, 8'h04, 32'h55, 8'h20, 32'h0,        5'b00100, 8'h04, 32'h55, 32'hDEADBEEF, 32'h0};
        tv[9]  = '{4'b0010, 8'h00, 32'h0,  8'h20, 32'h0,        5'b00100, 8'h04, 32'h55, 32'hDEADBEEF, 32'h0};
        tv[10] = '{4'b0010, 8'h00, 32'h0,  8'h20, 32'h0,        5'b01010, 8'h20, 32'h0,  32'hDEADBEEF, 32'h0};
        tv[11] = '{4'b0011, 8'h00, 32'h0,  8'h20, 32'h1234,     5'b01010, 8'h20, 32'h0,  32'hDEADBEEF, 32'h0};
        tv[12] = '{4'b0000, 8'h00, 32'h0,  8'h00, 32'h0,        5'b00001, 8'h20, 32'h0,  32'hDEADBEEF, 32'h1234};
        tv[13] = '{4'b0000, 8'h00, 32'h0,  8'h00, 32'h0,        5'b00000, 8'h20, 32'h0,  32'hDEADBEEF, 32'h1234};
        tv[14] = '{4'b0001, 8'h00, 32'h0,  8'h00, 32'hFFFFFFFF, 5'b00000, 8'h20, 32'h0,  32'hDEADBEEF, 32'h1234};
        tv[15] = '{4'b0000, 8'h00, 32'h0,  8'h00, 32'h0,        5'b00000, 8'h20, 32'h0,  32'hDEADBEEF, 32'h1234};
        tv[16] = '{4'b1100, 8'h08, 32'h77, 8'h00, 32'h0,        5'b10000, 8'h20, 32'h0,  32'hDEADBEEF, 32'h1234};
        tv[17] = '{4'b1101, 8'h08, 32'h77, 8'h00, 32'hBAD,      5'b11100, 8'h08, 32'h77, 32'hDEADBEEF, 32'h1234};
        tv[18] = '{4'b0000, 8'h00, 32'h0,  8'h00, 32'h0,        5'b00100, 8'h08, 32'h77, 32'hDEADBEEF, 32'h1234};
        tv[19] = '{4'b0000, 8'h00, 32'h0,  8'h00, 32'h0,        5'b00100, 8'h08, 32'h77, 32'hDEADBEEF, 32'h1234};
        m.ack = 1'b0;
        m.rdata = '0;
        #1 rst = 1'b0;
        #1;
        chk1("rst stall", stall, 1'b0);
        chk1("rst req", m.req, 1'b0);
        chk1("rst we", m.we, 1'b0);
        chk32("rst addr", {24'h0, m.addr}, 32'h0);
        chk32("rst wdata", m.wdata, 32'h0);
        chk1("rst gnt", dma_gnt, 1'b0);
        chk1("rst done", dma_done, 1'b0);
        chk32("rst prdata", pipe_rdata, 32'h0);
        chk32("rst drdata", dma_rdata, 32'h0);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            {pipe_rd, pipe_wr, dma_req, m.ack} = tv[i].ctl;
            pipe_addr = tv[i].pa;
            pipe_wdata = tv[i].pwd;
            dma_addr = tv[i].da;
            m.rdata = tv[i].rd;
            @(negedge clk);
            chk1($sformatf("v%0d stall", i), stall, tv[i].o[4]);
            chk1($sformatf("v%0d req", i), m.req, tv[i].o[3]);
            chk1($sformatf("v%0d we", i), m.we, tv[i].o[2]);
            chk1($sformatf("v%0d gnt", i), dma_gnt, tv[i].o[1]);
            chk1($sformatf("v%0d done", i), dma_done, tv[i].o[0]);
            chk32($sformatf("v%0d addr", i), {24'h0, m.addr}, {24'h0, tv[i].addr});
            chk32($sformatf("v%0d wdata", i), m.wdata, tv[i].wd);
            chk32($sformatf("v%0d prdata", i), pipe_rdata, tv[i].pr);
            chk32($sformatf("v%0d drdata", i), dma_rdata, tv[i].dr);
        end

        pipe_addr = 8'h30;
        pipe_wr = 1'b0;
        dma_addr = 8'h40;
        dma_we = 1'b1;
        dma_wdata = 32'h99;
        for (int t = 0; t < 14; t++) begin
            @(posedge clk); #1;
            pipe_rd = 1'b1;
            dma_req = (t <= 10);
            m.ack = m.req;
            m.rdata = 32'h100 + t;
            @(negedge clk);
            chk1($sformatf("C%0d stall", t), stall, stall_c[t]);
            chk1($sformatf("C%0d req", t), m.req, req_c[t]);
            chk1($sformatf("C%0d gnt", t), dma_gnt, t == 10);
            chk1($sformatf("C%0d done", t), dma_done, t == 11);
            if (t == 10) begin
                chk32("C dma addr", {24'h0, m.addr}, 32'h40);
                chk1("C dma we", m.we, 1'b1);
                chk32("C dma wdata", m.wdata, 32'h99);
            end
            if (t == 11) chk32("C drdata kept", dma_rdata, 32'h1234);
            if (t == 13) chk32("C prdata", pipe_rdata, 32'h10C);
        end
        pipe_rd = 1'b0;
        dma_req = 1'b0;
        dma_we = 1'b0;
        m.ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

`ifdef DMEM_ARB_TIMEOUT_EN
        n = 0;
        seen = 1'b0;
        pipe_addr = 8'h50;
        pipe_rd = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (m.req) n++;
            else if (n > 0 && !seen) begin
                seen = 1'b1;
                pipe_rd = 1'b0;
                chk32("T prdata", pipe_rdata, 32'h0);
                chk1("T err", err, 1'b1);
            end
        end
        chk32("T req cycles", n, 16);
        chk1("T err sticky", err, 1'b1);
        pipe_rd = 1'b0;
`endif

        pipe_addr = 8'h60;
        pipe_rd = 1'b1;
        @(posedge clk); #1;
        chk1("D pre req", m.req, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk1("D rst req", m.req, 1'b0);
        chk1("D rst stall", stall, 1'b0);
        chk1("D rst gnt", dma_gnt, 1'b0);
        pipe_rd = 1'b0;
        dma_req = 1'b1;
        dma_addr = 8'h70;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk1("D pre gnt", dma_gnt, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk1("D rst2 gnt", dma_gnt, 1'b0);
        chk1("D rst2 req", m.req, 1'b0);
        chk1("D rst2 done", dma_done, 1'b0);
        chk32("D rst2 prdata", pipe_rdata, 32'h0);
        chk32("D rst2 drdata", dma_rdata, 32'h0);
`ifdef DMEM_ARB_TIMEOUT_EN
        chk1("D rst2 err", err, 1'b0);
`endif
        dma_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        pipe_rd = 1'b1;
        @(negedge clk);
        chk1("D idle stall", stall, 1'b1);
        chk1("D idle req", m.req, 1'b0);
        @(posedge clk); #1;
        chk1("D acc req", m.req, 1'b1);
        chk32("D acc addr", {24'h0, m.addr}, 32'h60);
        chk1("D acc we", m.we, 1'b0);
        pipe_rd = 1'b0;
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates a single data-memory port between two requesters: the pipeline MEM stage and a secondary DMA/loader port.
- The MEM stage drives the load/store controls and address/data latched by the EXE/MEM pipeline register.
- The memory port uses a variable-latency req/ack handshake.
- Generates `stall` to freeze PC, IF/ID, ID/EXE and EXE/MEM while a pipeline access is outstanding, and prevents DMA starvation with an age counter.

Parameters:
- DW, 32: data width; matches `DSIZE.
- AW, 8: memory word-address width.
- MAX_WAIT, 8: consecutive cycles DMA may be denied before it takes priority.
- TIMEOUT, 64: ack timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pipe_rd  in  1  MEM-stage load (memRead from EXE/MEM).
- pipe_wr  in  1  MEM-stage store (memWrite from EXE/MEM).
- pipe_addr  in  AW  load/store address (ALU result from EXE/MEM).
- pipe_wdata  in  DW  store data.
- pipe_rdata  out  DW  load data; valid in P_DONE and held until the next pipe load completes.
- stall  out  1  freeze pipeline registers and PC.
- dma_req  in  1  DMA access request; held until dma_done.
- dma_we  in  1  DMA write when 1, read when 0.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_gnt  out  1  DMA access in progress.
- dma_done  out  1  one-cycle completion pulse.
- dma_rdata  out  DW  DMA read data; valid with dma_done and held afterwards.
- mem_req  out  1  memory request (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  AW  memory address (registered).
- mem_wdata  out  DW  memory write data (registered).
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Reset (rst=0, async): state=IDLE; age=0. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, dma_gnt, dma_done, pipe_rdata, dma_rdata, and stall (since state=IDLE and no pipe request).
- FSM states: IDLE, P_ACC, P_DONE, D_ACC.
- pipe_acc = pipe_rd | pipe_wr.
- stall (combinational) = pipe_acc & (state != P_DONE). It is asserted in the same cycle the MEM-stage op appears.
- IDLE:
  - If dma_req and (age==MAX_WAIT or !pipe_acc): go to D_ACC. Load mem_* from dma_*, set mem_req=1, set dma_gnt=1.
  - Else if pipe_acc: go to P_ACC. Load mem_* from pipe_*, mem_we=pipe_wr, mem_req=1.
  - If both pipe_rd and pipe_wr are high, treat as a store.
- P_ACC: hold mem_* stable. On mem_ack: mem_req=0; if load, latch pipe_rdata<=mem_rdata; go to P_DONE.
- P_DONE: stall=0 for exactly one cycle so the pipeline advances; go to IDLE. A back-to-back memory op is therefore re-arbitrated in IDLE on the next cycle.
- D_ACC: on mem_ack: mem_req=0, dma_gnt=0, dma_done=1 for one cycle; if read, latch dma_rdata; go to IDLE. Deasserting dma_req mid-access does not abort the access.
- Latency with a zero-wait memory (ack in the first cycle of mem_req): pipe op stalls 2 cycles (IDLE, P_ACC) and is released in P_DONE. A DMA op completes 2 cycles after being granted.
- Age counter:
  - Increments each cycle dma_req=1 and state != D_ACC, saturating at MAX_WAIT.
  - Clears on entry to D_ACC or when dma_req=0.
  - If dma_req is high in IDLE with no pipe request, DMA wins regardless of age.
- mem_ack in IDLE or P_DONE is ignored.
- Reset mid-access drops mem_req immediately. The memory must share the same reset.

Optional Feature:
- Macro DMEM_ARB_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in P_ACC and D_ACC.
  - If TIMEOUT cycles pass without mem_ack: mem_req drops and the FSM goes to P_DONE (pipe_rdata forced 0) or IDLE with a dma_done pulse (dma_rdata forced 0).
  - Extra output port `err` (1 bit): sticky, cleared only by reset.
- Undefined: no counter and no err port; the FSM waits indefinitely for ack.

Decomposition:
- Shared package/include: state encodings (IDLE=2'd0, P_ACC=2'd1, P_DONE=2'd2, D_ACC=2'd3) and the default DW/AW constants, alongside define.v.
- One sub-module: dmem_arb_age_cnt, the saturating starvation counter. Inputs: inc, clr. Outputs: count, sat.

Test Plan:
- Pipe load at addr 0x10, memory acks after 3 cycles with 0xDEADBEEF -> stall high 4 cycles; pipe_rdata=0xDEADBEEF in P_DONE; stall low for one cycle.
- Simultaneous pipe store (addr 0x04, data 0x55) and dma_req with age=0 -> pipe granted first (mem_we=1, mem_addr=0x04); DMA granted in the following IDLE when pipe_acc=0.
- Continuous pipe loads with dma_req held high, MAX_WAIT=8 -> age saturates at 8; DMA wins the next IDLE; stall stays high until DMA finishes and the pipe access completes.
- DMA read addr 0x20, ack data 0x1234 -> dma_gnt high until ack; dma_done exactly 1 cycle; dma_rdata=0x1234.
- rst pulled low during P_ACC -> mem_req, stall and dma_gnt go low immediately (async); FSM in IDLE after release.
- With DMEM_ARB_TIMEOUT_EN and TIMEOUT=16, ack never arrives -> mem_req drops after 16 cycles; err=1 and stays 1 until reset.
